comb_stim_seq: RTL and testbench
================================

COMB_STIM_SEQ -- requirements
Module: comb_stim_seq

Interface
REQ-001 Parameter SETTLE, default 2, meaning: cycles each input vector is held before Y is sampled; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  run request, sampled each rising edge.
REQ-005 golden  input  32  expected truth table; bit i = expected Y for vector i.
REQ-006 y_in  input  1  Y returned by the downstream combinational stage.
REQ-007 sel  output  1  vector bit 4 (MSB) to the combinational stage.
REQ-008 a  output  1  vector bit 3.
REQ-009 b  output  1  vector bit 2.
REQ-010 c  output  1  vector bit 1.
REQ-011 d  output  1  vector bit 0 (LSB).
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  high from run completion until next accepted start or reset.
REQ-014 pass  output  1  valid while done; 1 = zero mismatches.
REQ-015 sig  output  32  captured truth table; bit i = y_in sampled for vector i.
REQ-016 err_cnt  output  6  mismatch count, 0..32.

Function
REQ-017 FSM states: IDLE, APPLY, DONE; all outputs registered.
REQ-018 IDLE/DONE with start=1: next cycle state=APPLY, vec=0, hold counter=0, sig=0, err_cnt=0, done=0, pass=0, busy=1.
REQ-019 {sel,a,b,c,d} = 5-bit vec at all times; vec is 0 in IDLE; vec holds its final value (31) in DONE.
REQ-020 APPLY: hold counter increments each cycle from 0; in the cycle where counter = SETTLE-1, sig[vec] <= y_in and err_cnt increments iff y_in != golden[vec].
REQ-021 On that sample cycle, if vec < 31: vec increments by 1, counter clears to 0; each vector presented for exactly SETTLE cycles.
REQ-022 On the sample cycle with vec = 31: next state DONE, busy=0, done=1, pass = (final err_cnt including this sample == 0).
REQ-023 Run length: busy high for exactly 32*SETTLE cycles; done rises the cycle after the last sample.
REQ-024 Vector order ascending 0..31 with sel as MSB; no wrap back to 0 within a run.
REQ-025 start while busy=1 is ignored; no restart, no state change.
REQ-026 start held high continuously: one run per return to DONE; a new run starts the cycle after done rises.
REQ-027 err_cnt saturates naturally at 32 (6 bits); never wraps.
REQ-028 golden and y_in are used only on sample cycles; changes at other times have no effect.
REQ-029 sig and err_cnt hold their values in DONE until next accepted start or reset.

Reset
REQ-030 rst=1 on a rising edge: state=IDLE, vec=0, counter=0, sel=a=b=c=d=0, busy=0, done=0, pass=0, sig=0, err_cnt=0.
REQ-031 rst has priority over start and over any in-progress run; a run interrupted by reset is discarded, not resumed.
REQ-032 start sampled in the same cycle as rst=1 is ignored.

Verification
REQ-033 rst high 2 cycles, start=0 -> all outputs 0, state IDLE, remains so with no start.
REQ-034 SETTLE=2, golden=32'h0000_0000, y_in=0, 1-cycle start -> busy high 64 cycles, vectors 0..31 each held 2 cycles, then done=1, pass=1, sig=32'h0, err_cnt=0.
REQ-035 y_in modelled as d (vector LSB), golden=32'hAAAA_AAAA -> sig=32'hAAAA_AAAA, err_cnt=0, pass=1.
REQ-036 golden=32'h0000_0000, y_in=1 -> sig=32'hFFFF_FFFF, err_cnt=32, pass=0.
REQ-037 start pulsed again at vec=5 mid-run -> ignored, run completes at 64 cycles; rst asserted at vec=10 -> next cycle all outputs 0; subsequent start runs from vec=0 with fresh sig/err_cnt.
REQ-038 SETTLE=1, start held high -> back-to-back runs of 32 busy cycles separated by exactly one done cycle.

Source files
------------

// File: rtl/comb_stim_seq.sv
// Exhaustive stimulus sequencer: walks a 5-bit vector 0..31 into a combinational
// stage, holds each vector SETTLE cycles, captures Y into sig and counts golden mismatches.
// Latency: busy for 32*SETTLE cycles after an accepted start; no backpressure, start ignored while busy.
//
// Ports: clk/rst (sync, active-high), start, golden[31:0], y_in ->
//        sel,a,b,c,d (vector MSB..LSB), busy, done, pass, sig[31:0], err_cnt[5:0].
module comb_stim_seq #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] golden,
    input  logic        y_in,
    output logic        sel,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] sig,
    output logic [5:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      state, state_nxt;
    logic [4:0]  vec, vec_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] sig_nxt;
    logic [5:0]  err_nxt;
    logic        busy_nxt, done_nxt, pass_nxt;

    logic sample;
    logic last;
    logic accept;
    logic mis;

    // Y is only looked at on the final cycle of each hold window.
    assign sample = (state == APPLY) && (cnt == CNT_LAST);
    assign last   = sample && (vec == 5'd31);
    assign accept = (state != APPLY) && start;
    assign mis    = y_in ^ golden[vec];

    assign {sel, a, b, c, d} = vec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      if (last)  state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything lands in registers below.
    always_comb begin
        vec_nxt  = vec;
        cnt_nxt  = cnt;
        sig_nxt  = sig;
        err_nxt  = err_cnt;
        busy_nxt = busy;
        done_nxt = done;
        pass_nxt = pass;
        if (accept) begin
            vec_nxt  = 5'd0;
            cnt_nxt  = 4'd0;
            sig_nxt  = 32'd0;
            err_nxt  = 6'd0;
            busy_nxt = 1'b1;
            done_nxt = 1'b0;
            pass_nxt = 1'b0;
        end else if (state == APPLY) begin
            if (sample) begin
                sig_nxt[vec] = y_in;
                // At most 32 increments per run, so 6 bits never wrap.
                err_nxt      = err_cnt + 6'(mis);
                if (last) begin
                    // vec stays at 31 so the final vector remains visible in DONE.
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    pass_nxt = (err_cnt == 6'd0) && !mis;
                end else begin
                    vec_nxt = vec + 5'd1;
                    cnt_nxt = 4'd0;
                end
            end else begin
                cnt_nxt = cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec     <= 5'd0;
            cnt     <= 4'd0;
            sig     <= 32'd0;
            err_cnt <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            vec     <= vec_nxt;
            cnt     <= cnt_nxt;
            sig     <= sig_nxt;
            err_cnt <= err_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pass    <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_comb_stim_seq.sv
// Bench for comb_stim_seq: directed runs on a SETTLE=2 instance checked through
// an expected-result queue popped on each done rising edge, plus a SETTLE=1
// instance with start held high for back-to-back runs.
module tb_comb_stim_seq;

    localparam int S2 = 2;

    typedef struct packed {
        logic [31:0] sig;
        logic [5:0]  err;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    // SETTLE=2 instance
    logic        start2;
    logic [31:0] golden2, golden2_eff;
    logic        y2;
    logic        sel2, a2, b2, c2, d2, busy2, done2, pass2;
    logic [31:0] sig2;
    logic [5:0]  err2;
    logic [4:0]  vec2;
    int          ymode;

    // SETTLE=1 instance
    logic        start1;
    logic [31:0] golden1;
    logic        sel1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [31:0] sig1;
    logic [5:0]  err1;

    // Monitor state
    exp_t        exp_q[$];
    int          bidx = 0;
    int          run_len = 0;
    int          runs_seen = 0;
    bit          seq_ok = 1'b1;
    logic        prev_busy = 1'b0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    comb_stim_seq #(.SETTLE(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .golden(golden2_eff), .y_in(y2),
        .sel(sel2), .a(a2), .b(b2), .c(c2), .d(d2),
        .busy(busy2), .done(done2), .pass(pass2), .sig(sig2), .err_cnt(err2)
    );

    comb_stim_seq #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .golden(golden1), .y_in(d1),
        .sel(sel1), .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1), .sig(sig1), .err_cnt(err1)
    );

    assign vec2 = {sel2, a2, b2, c2, d2};

    // Mode 0: y=0, 1: y=1, 2: y=d, 3: y and golden toggle on non-sample cycles
    // (first cycle of each hold) and are 0 / golden on the sample cycle.
    always_comb begin
        y2          = 1'b0;
        golden2_eff = golden2;
        case (ymode)
            1: y2 = 1'b1;
            2: y2 = d2;
            3: begin
                y2 = (bidx[0] == 1'b0);
                if (bidx[0] == 1'b0) golden2_eff = ~golden2;
            end
            default: y2 = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the SETTLE=2 instance.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy2 && !prev_busy) begin
                bidx   = 0;
                seq_ok = 1'b1;
            end else if (busy2) begin
                bidx++;
            end
            if (busy2 && vec2 != 5'(bidx / S2)) seq_ok = 1'b0;
            if (!busy2 && prev_busy) run_len = bidx + 1;
            if (done2 && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_depth_at_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sig", sig2, e.sig);
                    chk("err_cnt", 32'(err2), 32'(e.err));
                    chk("pass", 32'(pass2), 32'(e.pass));
                    chk("busy_cycles", 32'(run_len), 32'(32 * S2));
                    chk("vector_sequence", 32'(seq_ok), 32'd1);
                    chk("vec_in_done", 32'(vec2), 32'd31);
                end
                runs_seen++;
            end
            prev_busy = busy2;
            prev_done = done2;
        end
    end

    task automatic check_idle2(input string tag);
        chk({tag, "_vec"},  32'(vec2),  32'd0);
        chk({tag, "_busy"}, 32'(busy2), 32'd0);
        chk({tag, "_done"}, 32'(done2), 32'd0);
        chk({tag, "_pass"}, 32'(pass2), 32'd0);
        chk({tag, "_sig"},  sig2,       32'd0);
        chk({tag, "_err"},  32'(err2),  32'd0);
    endtask

    task automatic run2(input logic [31:0] g, input int mode, input logic [31:0] es,
                        input logic [5:0] ee, input logic ep, input bit mid);
        int  seen0;
        int  guard;
        bit  pulsed;
        golden2 = g;
        ymode   = mode;
        exp_q.push_back('{sig: es, err: ee, pass: ep});
        seen0  = runs_seen;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        guard  = 0;
        pulsed = 1'b0;
        while (runs_seen == seen0 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (start2) begin
                start2 = 1'b0;
            end else if (mid && !pulsed && busy2 && vec2 == 5'd5) begin
                start2 = 1'b1;
                pulsed = 1'b1;
            end
        end
        start2 = 1'b0;
        chk("run_completed_in_budget", 32'(guard < 300), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_held", 32'(done2), 32'd1);
        chk("sig_held", sig2, es);
        chk("err_held", 32'(err2), 32'(ee));
        chk("busy_low_in_done", 32'(busy2), 32'd0);
    endtask

    initial begin
        int n;
        int guard;
        rst     = 1'b1;
        start2  = 1'b0;
        start1  = 1'b0;
        golden2 = 32'd0;
        golden1 = 32'hAAAA_AAAA;
        ymode   = 0;
        repeat (2) @(negedge clk);
        check_idle2("reset");
        chk("reset_dut1_busy", 32'(busy1), 32'd0);
        chk("reset_dut1_done", 32'(done1), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle2("idle_no_start");

        run2(32'h0000_0000, 0, 32'h0000_0000, 6'd0,  1'b1, 1'b0);
        run2(32'hAAAA_AAAA, 2, 32'hAAAA_AAAA, 6'd0,  1'b1, 1'b0);
        run2(32'h0000_0000, 1, 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
        run2(32'h0000_0000, 2, 32'hAAAA_AAAA, 6'd16, 1'b0, 1'b0);
        run2(32'hFFFF_FFFF, 2, 32'hAAAA_AAAA, 6'd16, 1'b0, 1'b0);
        // Off-sample toggling of y/golden plus a start pulse at vec=5.
        run2(32'h0000_0000, 3, 32'h0000_0000, 6'd0,  1'b1, 1'b1);

        // Reset in the middle of a run, with start asserted alongside it.
        golden2 = 32'd0;
        ymode   = 1;
        start2  = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        guard  = 0;
        while (vec2 != 5'd10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_vec10", 32'(vec2), 32'd10);
        rst    = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        check_idle2("midrun_reset");
        rst    = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        chk("start_with_rst_ignored", 32'(busy2), 32'd0);
        run2(32'h0000_0000, 1, 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);

        // SETTLE=1, start held high: 32 busy cycles, one done cycle, repeat.
        start1 = 1'b1;
        n      = 0;
        guard  = 0;
        do begin
            @(negedge clk);
            if (busy1) n++;
            guard++;
        end while (!done1 && guard < 200);
        chk("s1_run1_busy_cycles", 32'(n), 32'd32);
        chk("s1_run1_sig", sig1, 32'hAAAA_AAAA);
        chk("s1_run1_pass", 32'(pass1), 32'd1);
        @(negedge clk);
        chk("s1_single_done_cycle", 32'({done1, busy1}), 32'b01);
        n     = 1;
        guard = 0;
        do begin
            @(negedge clk);
            if (busy1) n++;
            guard++;
        end while (!done1 && guard < 200);
        chk("s1_run2_busy_cycles", 32'(n), 32'd32);
        chk("s1_run2_err", 32'(err1), 32'd0);
        start1 = 1'b0;

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
